// File: rtl/exhaust_mode_scheduler.sv
// Range hood exhaust mode scheduler: key-driven fan modes with timed
// hurricane, self-clean and delayed-off states counted down by a 1 s tick.
module exhaust_mode_scheduler #(
    parameter int HURRICANE_SEC = 60,
    parameter int CLEAN_SEC     = 180,
    parameter int OFF_DELAY_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_key,
    input  logic       first_key,
    input  logic       second_key,
    input  logic       third_key,
    input  logic       clean_key,
    input  logic       tick_1s,
    output logic [2:0] current_mode,
    output logic [1:0] fan_speed,
    output logic [7:0] remaining_sec,
    output logic       third_used,
    output logic       clean_done
);

    if (HURRICANE_SEC < 1 || HURRICANE_SEC > 255 ||
        CLEAN_SEC     < 1 || CLEAN_SEC     > 255 ||
        OFF_DELAY_SEC < 1 || OFF_DELAY_SEC > 255) begin : g_bad_param
        $error("exhaust_mode_scheduler: durations must lie in 1..255");
    end

    typedef enum logic [2:0] {
        MODE_OFF      = 3'd0,
        MODE_STANDBY  = 3'd1,
        MODE_FIRST    = 3'd2,
        MODE_SECOND   = 3'd3,
        MODE_THIRD    = 3'd4,
        MODE_CLEAN    = 3'd5,
        MODE_WAIT_OFF = 3'd6
    } mode_e;

    mode_e      mode_q, mode_d;
    logic [1:0] fan_q, fan_d;
    logic [7:0] remaining_q, remaining_d;
    logic       third_used_q, third_used_d;
    logic       clean_done_q, clean_done_d;
    logic       expire;
    logic       count;

    // A tick with one second left is the expiry event, never a plain decrement.
    assign expire = tick_1s && (remaining_q == 8'd1);
    assign count  = tick_1s && (remaining_q > 8'd1);

    always_comb begin
        mode_d       = mode_q;
        remaining_d  = remaining_q;
        third_used_d = third_used_q;
        clean_done_d = 1'b0;

        // Within each mode, only keys that mode honours compete for priority.
        unique case (mode_q)
            MODE_OFF: begin
                if (power_key) mode_d = MODE_STANDBY;
            end
            MODE_STANDBY: begin
                if (power_key) begin
                    mode_d = MODE_OFF;
                end else if (clean_key) begin
                    mode_d      = MODE_CLEAN;
                    remaining_d = 8'(CLEAN_SEC);
                end else if (third_key && !third_used_q) begin
                    mode_d       = MODE_THIRD;
                    remaining_d  = 8'(HURRICANE_SEC);
                    third_used_d = 1'b1;
                end else if (second_key) begin
                    mode_d = MODE_SECOND;
                end else if (first_key) begin
                    mode_d = MODE_FIRST;
                end
            end
            MODE_FIRST, MODE_SECOND: begin
                if (power_key) begin
                    mode_d = MODE_OFF;
                end else if (third_key && !third_used_q) begin
                    mode_d       = MODE_THIRD;
                    remaining_d  = 8'(HURRICANE_SEC);
                    third_used_d = 1'b1;
                end else if (second_key) begin
                    mode_d = MODE_SECOND;
                end else if (first_key) begin
                    mode_d = MODE_FIRST;
                end
            end
            MODE_THIRD: begin
                if (power_key) begin
                    mode_d      = MODE_WAIT_OFF;
                    remaining_d = 8'(OFF_DELAY_SEC);
                end else if (expire) begin
                    mode_d = MODE_SECOND;
                end else if (count) begin
                    remaining_d = remaining_q - 8'd1;
                end
            end
            MODE_WAIT_OFF: begin
                if (expire) begin
                    mode_d = MODE_OFF;
                end else if (count) begin
                    remaining_d = remaining_q - 8'd1;
                end
            end
            MODE_CLEAN: begin
                if (power_key) begin
                    mode_d = MODE_OFF;
                end else if (expire) begin
                    mode_d       = MODE_STANDBY;
                    clean_done_d = 1'b1;
                end else if (count) begin
                    remaining_d = remaining_q - 8'd1;
                end
            end
            default: begin
                mode_d = MODE_OFF;
            end
        endcase

        if (mode_d == MODE_OFF) third_used_d = 1'b0;

        unique case (mode_d)
            MODE_OFF, MODE_STANDBY, MODE_FIRST, MODE_SECOND: remaining_d = 8'd0;
            default: ;
        endcase

        unique case (mode_d)
            MODE_FIRST:                fan_d = 2'd1;
            MODE_SECOND, MODE_WAIT_OFF: fan_d = 2'd2;
            MODE_THIRD:                fan_d = 2'd3;
            default:                   fan_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_OFF;
            fan_q        <= 2'd0;
            remaining_q  <= 8'd0;
            third_used_q <= 1'b0;
            clean_done_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            fan_q        <= fan_d;
            remaining_q  <= remaining_d;
            third_used_q <= third_used_d;
            clean_done_q <= clean_done_d;
        end
    end

    assign current_mode  = mode_q;
    assign fan_speed     = fan_q;
    assign remaining_sec = remaining_q;
    assign third_used    = third_used_q;
    assign clean_done    = clean_done_q;

endmodule

// File: tb/tb_exhaust_mode_scheduler.sv
// Self-checking bench for exhaust_mode_scheduler: vector table, directed
// multi-cycle scenarios and random stimulus against a rule-level model.
module tb_exhaust_mode_scheduler;

    localparam int KP = 4, KC = 3, KT = 2, KS = 1, KF = 0;
    localparam int M_OFF = 0, M_STBY = 1, M_FIRST = 2, M_SECOND = 3;
    localparam int M_THIRD = 4, M_CLEAN = 5, M_WAIT = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_key, first_key, second_key, third_key, clean_key, tick_1s;
    logic [2:0] current_mode;
    logic [1:0] fan_speed;
    logic [7:0] remaining_sec;
    logic       third_used;
    logic       clean_done;

    int passCount = 0;
    int checkCount = 0;

    int m_mode, m_rem, m_used, m_done;

    exhaust_mode_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .power_key     (power_key),
        .first_key     (first_key),
        .second_key    (second_key),
        .third_key     (third_key),
        .clean_key     (clean_key),
        .tick_1s       (tick_1s),
        .current_mode  (current_mode),
        .fan_speed     (fan_speed),
        .remaining_sec (remaining_sec),
        .third_used    (third_used),
        .clean_done    (clean_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       r;
        logic [4:0] keys;
        logic       tick;
        int         mode;
        int         fan;
        int         rem;
        int         used;
        int         done;
    } vec_t;

    vec_t vecs[$];

    function automatic int fanOf(input int mode);
        int table_f[7] = '{0, 0, 1, 2, 3, 0, 2};
        return table_f[mode];
    endfunction

    // Which keys a mode listens to at all, given the third-mode session flag.
    function automatic bit keyLegal(input int mode, input int k, input int used);
        case (mode)
            M_OFF:             return k == KP;
            M_STBY:            return (k != KT) || (used == 0);
            M_FIRST, M_SECOND: return (k == KP) || (k == KS) || (k == KF) ||
                                      (k == KT && used == 0);
            M_THIRD, M_CLEAN:  return k == KP;
            default:           return 1'b0;
        endcase
    endfunction

    task automatic modelStep(input logic r, input logic [4:0] keys, input logic tick);
        int acc;
        if (r) begin
            m_mode = M_OFF; m_rem = 0; m_used = 0; m_done = 0;
            return;
        end
        m_done = 0;
        acc = -1;
        for (int k = 4; k >= 0; k--) begin
            if (acc < 0 && keys[k] && keyLegal(m_mode, k, m_used)) acc = k;
        end
        if (acc == KP) begin
            if (m_mode == M_OFF)        begin m_mode = M_STBY; end
            else if (m_mode == M_THIRD) begin m_mode = M_WAIT; m_rem = 60; end
            else                        begin m_mode = M_OFF; end
        end else if (acc == KC) begin
            m_mode = M_CLEAN; m_rem = 180;
        end else if (acc == KT) begin
            m_mode = M_THIRD; m_rem = 60; m_used = 1;
        end else if (acc == KS) begin
            m_mode = M_SECOND;
        end else if (acc == KF) begin
            m_mode = M_FIRST;
        end else if (tick && (m_mode == M_THIRD || m_mode == M_WAIT || m_mode == M_CLEAN)) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                if (m_mode == M_THIRD)     m_mode = M_SECOND;
                else if (m_mode == M_WAIT) m_mode = M_OFF;
                else begin m_mode = M_STBY; m_done = 1; end
            end
        end
        if (m_mode == M_OFF) m_used = 0;
        if (m_mode <= M_SECOND) m_rem = 0;
    endtask

    // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
    task automatic applyStimulus(input logic r, input logic [4:0] keys, input logic tick);
        rst        = r;
        power_key  = keys[KP];
        clean_key  = keys[KC];
        third_key  = keys[KT];
        second_key = keys[KS];
        first_key  = keys[KF];
        tick_1s    = tick;
        @(negedge clk);
        rst = 1'b0; power_key = 1'b0; clean_key = 1'b0; third_key = 1'b0;
        second_key = 1'b0; first_key = 1'b0; tick_1s = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int mode, input int fan,
                               input int rem, input int used, input int done);
        checkCount++;
        if (int'(current_mode) == mode && int'(fan_speed) == fan && int'(remaining_sec) == rem &&
            int'(third_used) == used && int'(clean_done) == done) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0d done=%0d, expected mode=%0d fan=%0d rem=%0d used=%0d done=%0d",
                     name, current_mode, fan_speed, remaining_sec, third_used, clean_done,
                     mode, fan, rem, used, done);
        end
    endtask

    task automatic ticks(input int n, input string name, input int mode, input int fan,
                         input int startRem, input int used);
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b0, 5'b0, 1'b1);
            checkOutput(name, mode, fan, startRem - i, used, 0);
        end
    endtask

    localparam logic [4:0] P = 5'b10000, C = 5'b01000, T = 5'b00100, S = 5'b00010, F = 5'b00001, N = 5'b0;

    initial begin
        rst = 1'b1; power_key = 1'b0; first_key = 1'b0; second_key = 1'b0;
        third_key = 1'b0; clean_key = 1'b0; tick_1s = 1'b0;

        vecs.push_back('{"rst_with_power", 1, P,         0, 0, 0, 0,   0, 0});
        vecs.push_back('{"off_ignores",    0, C|T|S|F,   1, 0, 0, 0,   0, 0});
        vecs.push_back('{"power_on",       0, P,         0, 1, 0, 0,   0, 0});
        vecs.push_back('{"prio_clean",     0, C|S|F,     0, 5, 0, 180, 0, 0});
        vecs.push_back('{"clean_tick",     0, N,         1, 5, 0, 179, 0, 0});
        vecs.push_back('{"clean_ign_keys", 0, T|S|F,     1, 5, 0, 178, 0, 0});
        vecs.push_back('{"clean_abort",    0, P,         1, 0, 0, 0,   0, 0});
        vecs.push_back('{"power_on2",      0, P,         0, 1, 0, 0,   0, 0});
        vecs.push_back('{"first",          0, F,         0, 2, 1, 0,   0, 0});
        vecs.push_back('{"second",         0, S,         0, 3, 2, 0,   0, 0});
        vecs.push_back('{"second_no_clean",0, C,         0, 3, 2, 0,   0, 0});
        vecs.push_back('{"third_tick",     0, T,         1, 4, 3, 60,  1, 0});
        vecs.push_back('{"third_count",    0, N,         1, 4, 3, 59,  1, 0});
        vecs.push_back('{"third_ign_keys", 0, C|T|S|F,   1, 4, 3, 58,  1, 0});
        vecs.push_back('{"third_to_wait",  0, P,         1, 6, 2, 60,  1, 0});
        vecs.push_back('{"wait_ign_keys",  0, P|C|T|S|F, 1, 6, 2, 59,  1, 0});
        vecs.push_back('{"rst_mid_wait",   1, N,         1, 0, 0, 0,   0, 0});

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].keys, vecs[i].tick);
            checkOutput(vecs[i].name, vecs[i].mode, vecs[i].fan, vecs[i].rem,
                        vecs[i].used, vecs[i].done);
        end

        applyStimulus(1'b0, P, 1'b0);
        checkOutput("a_standby", 1, 0, 0, 0, 0);
        applyStimulus(1'b0, T, 1'b0);
        checkOutput("a_third", 4, 3, 60, 1, 0);
        ticks(59, "a_countdown", 4, 3, 60, 1);
        applyStimulus(1'b0, N, 1'b1);
        checkOutput("a_third_expiry", 3, 2, 0, 1, 0);
        applyStimulus(1'b0, N, 1'b1);
        checkOutput("a_second_idle_tick", 3, 2, 0, 1, 0);
        applyStimulus(1'b0, T, 1'b0);
        checkOutput("a_third_reuse", 3, 2, 0, 1, 0);
        applyStimulus(1'b0, P, 1'b0);
        checkOutput("a_off_clears", 0, 0, 0, 0, 0);
        applyStimulus(1'b0, P, 1'b0);
        checkOutput("a_standby_again", 1, 0, 0, 0, 0);

        applyStimulus(1'b0, C, 1'b1);
        checkOutput("b_clean_tick_load", 5, 0, 180, 0, 0);
        ticks(179, "b_clean_count", 5, 0, 180, 0);
        applyStimulus(1'b0, N, 1'b1);
        checkOutput("b_clean_done", 1, 0, 0, 0, 1);
        applyStimulus(1'b0, N, 1'b1);
        checkOutput("b_done_one_cycle", 1, 0, 0, 0, 0);
        applyStimulus(1'b0, C, 1'b0);
        checkOutput("b_clean_again", 5, 0, 180, 0, 0);
        ticks(49, "b_clean_count2", 5, 0, 180, 0);
        applyStimulus(1'b0, P, 1'b1);
        checkOutput("b_abort_at_50", 0, 0, 0, 0, 0);
        applyStimulus(1'b0, N, 1'b0);
        checkOutput("b_no_pulse", 0, 0, 0, 0, 0);

        applyStimulus(1'b0, P, 1'b0);
        applyStimulus(1'b0, T, 1'b0);
        ticks(30, "c_third_count", 4, 3, 60, 1);
        applyStimulus(1'b0, P, 1'b0);
        checkOutput("c_wait_off", 6, 2, 60, 1, 0);
        ticks(59, "c_wait_count", 6, 2, 60, 1);
        applyStimulus(1'b0, N, 1'b1);
        checkOutput("c_wait_expiry", 0, 0, 0, 0, 0);

        applyStimulus(1'b0, P, 1'b0);
        applyStimulus(1'b0, C, 1'b0);
        ticks(90, "d_clean_count", 5, 0, 180, 0);
        applyStimulus(1'b1, P, 1'b1);
        checkOutput("d_rst_mid_clean", 0, 0, 0, 0, 0);
        applyStimulus(1'b0, N, 1'b1);
        checkOutput("d_no_pulse", 0, 0, 0, 0, 0);

        applyStimulus(1'b1, N, 1'b0);
        modelStep(1'b1, N, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic       r;
            logic [4:0] keys;
            logic       tick;
            r    = ($urandom_range(0, 399) == 0);
            keys = 5'b0;
            if ($urandom_range(0, 9) == 0) keys[$urandom_range(0, 4)] = 1'b1;
            if (keys[KP] && $urandom_range(0, 2) != 0) keys = 5'b0;
            tick = ($urandom_range(0, 1) == 1);
            applyStimulus(r, keys, tick);
            modelStep(r, keys, tick);
            checkOutput("random", m_mode, fanOf(m_mode), m_rem, m_used, m_done);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/exhaust_mode_scheduler.md
EXHAUST_MODE_SCHEDULER -- requirements
Module: exhaust_mode_scheduler

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- HURRICANE_SEC  60   third-mode duration in seconds
- CLEAN_SEC      180  self-clean duration in seconds
- OFF_DELAY_SEC  60   delayed-off duration after leaving third mode
REQ-002 Each parameter SHALL be in the range 1..255; any other value is illegal.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk            in   1  single clock; all logic on the rising edge
- rst            in   1  synchronous, active-high reset
- power_key      in   1  one-cycle pulse; power toggle request
- first_key      in   1  one-cycle pulse; first-mode request
- second_key     in   1  one-cycle pulse; second-mode request
- third_key      in   1  one-cycle pulse; third (hurricane) mode request
- clean_key      in   1  one-cycle pulse; self-clean request
- tick_1s        in   1  one-cycle pulse, once per second
- current_mode   out  3  OFF=0, STANDBY=1, FIRST=2, SECOND=3, THIRD=4, CLEAN=5, WAIT_OFF=6
- fan_speed      out  2  fan drive level
- remaining_sec  out  8  countdown of the timed states
- third_used     out  1  third mode already taken in this power-on session
- clean_done     out  1  one-cycle pulse when self-clean completes

Function
REQ-004 All outputs SHALL be registered; a key accepted in cycle N SHALL show its new mode, counter and fan value in cycle N+1.
REQ-005 When several keys arrive in one cycle, the block SHALL accept only one, in this priority order: power, clean, third, second, first.
REQ-006 Transitions out of OFF: power_key SHALL go to STANDBY; all other keys SHALL be ignored.
REQ-007 Transitions out of STANDBY:
- first_key SHALL go to FIRST.
- second_key SHALL go to SECOND.
- clean_key SHALL go to CLEAN and load CLEAN_SEC.
- power_key SHALL go to OFF.
REQ-008 Transitions out of FIRST and SECOND:
- first_key and second_key SHALL switch between FIRST and SECOND.
- power_key SHALL go to OFF.
- clean_key SHALL be ignored.
REQ-009 From STANDBY, FIRST or SECOND, when third_used=0, third_key SHALL go to THIRD, load HURRICANE_SEC and set third_used; when third_used=1, third_key SHALL be ignored.
REQ-010 Behaviour in THIRD:
- first_key, second_key, third_key and clean_key SHALL be ignored.
- power_key SHALL go to WAIT_OFF and load OFF_DELAY_SEC.
- At expiry the block SHALL go to SECOND.
REQ-011 Behaviour in WAIT_OFF: all keys SHALL be ignored; at expiry the block SHALL go to OFF.
REQ-012 Behaviour in CLEAN:
- power_key SHALL abort to OFF with no clean_done.
- Other keys SHALL be ignored.
- At expiry the block SHALL go to STANDBY and pulse clean_done for exactly 1 cycle.
REQ-013 Countdown rule in THIRD, WAIT_OFF and CLEAN:
- tick_1s SHALL decrement remaining_sec by 1.
- A tick with remaining_sec=1 is the expiry event: remaining_sec SHALL become 0 and the exit transition SHALL be taken in the same update.
- remaining_sec SHALL never wrap below 0.
REQ-014 If an accepted key and tick_1s coincide, the key SHALL take effect; the tick SHALL be discarded and SHALL NOT decrement the newly loaded value.
REQ-015 remaining_sec SHALL be 0 in OFF, STANDBY, FIRST and SECOND.
REQ-016 fan_speed SHALL be 0 in OFF, STANDBY and CLEAN; 1 in FIRST; 2 in SECOND and WAIT_OFF; 3 in THIRD.
REQ-017 third_used SHALL clear on any entry to OFF and SHALL otherwise hold.
REQ-018 clean_done SHALL be 0 in every cycle except the one following CLEAN expiry.

Reset
REQ-019 When rst=1 at a clock edge, the outputs SHALL take these values: current_mode=0 (OFF), fan_speed=0, remaining_sec=0, third_used=0, clean_done=0.
REQ-020 rst SHALL override every key and tick in the same cycle.
REQ-021 A reset asserted mid-countdown SHALL abandon the timer with no clean_done pulse.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
- power_key, then third_key -> mode 1 then 4, fan 3, remaining 60, third_used 1; 60 ticks -> mode 3, fan 2, remaining 0.
- From SECOND after third use, third_key -> no change; power_key, power_key -> STANDBY with third_used 0.
- STANDBY, clean_key, 180 ticks -> mode 5 counting 180..1, then mode 1 with clean_done high 1 cycle; power_key at tick 50 instead -> OFF, no pulse.
- THIRD at remaining 30, power_key -> mode 6, remaining 60, fan 2; 60 ticks -> mode 0.
- STANDBY with first_key, second_key and clean_key in the same cycle -> CLEAN only; clean_key with tick_1s in the same cycle -> remaining 180.
- rst asserted during CLEAN at remaining 90 -> all outputs 0 next cycle; rst together with power_key -> stays OFF.
